// File: rtl/mastermind_pkg.sv
// ============================================================================
// mastermind_pkg : shared constants, scorer state encoding, slot helpers
// Revision: 1.0
// ============================================================================
`default_nettype none

package mastermind_pkg;

  localparam int N_POS    = 4;
  localparam int COLOR_W  = 3;
  localparam int N_COLORS = 6;
  localparam int WORD_W   = N_POS * COLOR_W;
  localparam int CNT_W    = 3;

  localparam logic [COLOR_W-1:0] COLOR_EMPTY = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXACT = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } scorer_state_t;

  function automatic logic [COLOR_W-1:0] slot_of(input logic [WORD_W-1:0] word, input int idx);
    return COLOR_W'(word >> (idx * COLOR_W));
  endfunction

  function automatic logic color_legal(input logic [COLOR_W-1:0] color);
    return (color != COLOR_EMPTY) && (color <= COLOR_W'(N_COLORS));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mastermind_scorer_if.sv
// ============================================================================
// mastermind_scorer_if : request/result bundle; invalid exists only with
// GUESS_VALIDATE_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

interface mastermind_scorer_if;
  import mastermind_pkg::*;

  logic                start;
  logic [WORD_W-1:0]   guess;
  logic [WORD_W-1:0]   answer;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    exact;
  logic [CNT_W-1:0]    partial;
  logic                win;

`ifdef GUESS_VALIDATE_EN
  logic                invalid;

  modport master (output start, guess, answer,
                  input  busy, done, exact, partial, win, invalid);
  modport slave  (input  start, guess, answer,
                  output busy, done, exact, partial, win, invalid);
`else
  modport master (output start, guess, answer,
                  input  busy, done, exact, partial, win);
  modport slave  (input  start, guess, answer,
                  output busy, done, exact, partial, win);
`endif

endinterface

`default_nettype wire

// File: rtl/mastermind_color_count.sv
// ============================================================================
// mastermind_color_count : combinational count of one colour across a word
// Revision: 1.0
// ============================================================================
`default_nettype none

module mastermind_color_count
  import mastermind_pkg::*;
(
  input  wire logic [WORD_W-1:0]  i_word,
  input  wire logic [COLOR_W-1:0] i_color,
  output logic      [CNT_W-1:0]   o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N_POS; i++) begin
      if (slot_of(i_word, i) == i_color) begin
        o_count = o_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mastermind_scorer.sv
// ============================================================================
// mastermind_scorer : multi-cycle Mastermind exact/partial scorer.
// Optional guess validation via GUESS_VALIDATE_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module mastermind_scorer
  import mastermind_pkg::*;
(
  input  wire logic          Clk,
  input  wire logic          Reset,
  mastermind_scorer_if.slave bus
);

  localparam logic [1:0]         POS_LAST = 2'(N_POS - 1);
  localparam logic [COLOR_W-1:0] C_FIRST  = COLOR_W'(1);
  localparam logic [COLOR_W-1:0] C_LAST   = COLOR_W'(N_COLORS);

  scorer_state_t      state_q, state_d;
  logic [WORD_W-1:0]  g_q, g_d, a_q, a_d;
  logic [1:0]         pos_q, pos_d;
  logic [COLOR_W-1:0] c_q, c_d;
  logic [CNT_W-1:0]   exact_acc_q, exact_acc_d;
  logic [3:0]         total_acc_q, total_acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   exact_q, exact_d;
  logic [CNT_W-1:0]   partial_q, partial_d;
  logic               win_q, win_d;
`ifdef GUESS_VALIDATE_EN
  logic               bad_q, bad_d;
  logic               invalid_q, invalid_d;
`endif

  logic [CNT_W-1:0]   ng, na, min_cnt;
  logic [3:0]         total_sum;
  logic [COLOR_W-1:0] g_slot, a_slot;

  mastermind_color_count u_count_guess (
    .i_word  (g_q),
    .i_color (c_q),
    .o_count (ng)
  );

  mastermind_color_count u_count_answer (
    .i_word  (a_q),
    .i_color (c_q),
    .o_count (na)
  );

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    a_d         = a_q;
    pos_d       = pos_q;
    c_d         = c_q;
    exact_acc_d = exact_acc_q;
    total_acc_d = total_acc_q;
    done_d      = 1'b0;
    exact_d     = exact_q;
    partial_d   = partial_q;
    win_d       = win_q;
`ifdef GUESS_VALIDATE_EN
    bad_d       = bad_q;
    invalid_d   = invalid_q;
`endif

    g_slot    = slot_of(g_q, int'(pos_q));
    a_slot    = slot_of(a_q, int'(pos_q));
    min_cnt   = (ng < na) ? ng : na;
    total_sum = total_acc_q + {1'b0, min_cnt};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          g_d         = bus.guess;
          a_d         = bus.answer;
          exact_acc_d = '0;
          total_acc_d = '0;
          pos_d       = '0;
`ifdef GUESS_VALIDATE_EN
          bad_d       = 1'b0;
`endif
          state_d     = ST_EXACT;
        end
      end

      ST_EXACT: begin
        if ((g_slot == a_slot) && color_legal(g_slot)) begin
          exact_acc_d = exact_acc_q + CNT_W'(1);
        end
`ifdef GUESS_VALIDATE_EN
        if (!color_legal(g_slot)) begin
          bad_d = 1'b1;
        end
`endif
        if (pos_q == POS_LAST) begin
          c_d     = C_FIRST;
          state_d = ST_COUNT;
        end else begin
          pos_d = pos_q + 2'd1;
        end
      end

      ST_COUNT: begin
        total_acc_d = total_sum;
        if (c_q == C_LAST) begin
          // Results are registered on entry to DONE so they are valid with done.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          exact_d   = exact_acc_q;
          partial_d = CNT_W'(total_sum - {1'b0, exact_acc_q});
          win_d     = (exact_acc_q == CNT_W'(N_POS));
`ifdef GUESS_VALIDATE_EN
          invalid_d = bad_q;
          if (bad_q) begin
            exact_d   = '0;
            partial_d = '0;
            win_d     = 1'b0;
          end
`endif
        end else begin
          c_d = c_q + C_FIRST;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      a_q         <= '0;
      pos_q       <= '0;
      c_q         <= '0;
      exact_acc_q <= '0;
      total_acc_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exact_q     <= '0;
      partial_q   <= '0;
      win_q       <= 1'b0;
`ifdef GUESS_VALIDATE_EN
      bad_q       <= 1'b0;
      invalid_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      a_q         <= a_d;
      pos_q       <= pos_d;
      c_q         <= c_d;
      exact_acc_q <= exact_acc_d;
      total_acc_q <= total_acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      exact_q     <= exact_d;
      partial_q   <= partial_d;
      win_q       <= win_d;
`ifdef GUESS_VALIDATE_EN
      bad_q       <= bad_d;
      invalid_q   <= invalid_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.exact   = exact_q;
  assign bus.partial = partial_q;
  assign bus.win     = win_q;
`ifdef GUESS_VALIDATE_EN
  assign bus.invalid = invalid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mastermind_scorer.sv
// ============================================================================
// tb_mastermind_scorer : randomized and directed bench with a behavioural
// scoring model.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mastermind_scorer;

  logic Clk;
  logic Reset;
  int   vectors     = 0;
  int   miscompares = 0;

  mastermind_scorer_if bus ();

  mastermind_scorer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [11:0] pack(input int s0, input int s1, input int s2, input int s3);
    return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
  endfunction

  // Classic Mastermind scoring straight from the game rules.
  function automatic void score(input logic [11:0] g, input logic [11:0] a,
                                output int ex, output int pa, output int wi, output int inv);
    int gs[4];
    int as[4];
    int total;
    ex = 0; inv = 0; total = 0;
    for (int i = 0; i < 4; i++) begin
      gs[i] = int'((g >> (3 * i)) & 12'h7);
      as[i] = int'((a >> (3 * i)) & 12'h7);
      if (gs[i] == as[i] && gs[i] >= 1 && gs[i] <= 6) ex++;
      if (gs[i] == 0 || gs[i] > 6) inv = 1;
    end
    for (int c = 1; c <= 6; c++) begin
      int ng, na;
      ng = 0; na = 0;
      for (int i = 0; i < 4; i++) begin
        if (gs[i] == c) ng++;
        if (as[i] == c) na++;
      end
      total += (ng < na) ? ng : na;
    end
    pa = total - ex;
    wi = (ex == 4) ? 1 : 0;
`ifdef GUESS_VALIDATE_EN
    if (inv == 1) begin ex = 0; pa = 0; wi = 0; end
`else
    inv = 0;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Cycle-level expectation: operation occupies 11 cycles after the start edge.
  int          edge_n = 0;
  int          acc_e  = 0;
  bit          active = 0;
  logic [11:0] mg, ma;
  int m_busy = 0, m_done = 0, m_exact = 0, m_partial = 0, m_win = 0, m_inv = 0;

  always @(posedge Clk) begin
    int ex, pa, wi, inv;
    edge_n++;
    if (Reset) begin
      active = 0; m_busy = 0; m_done = 0;
      m_exact = 0; m_partial = 0; m_win = 0; m_inv = 0;
    end else begin
      m_done = 0;
      if (active && edge_n == acc_e + 10) begin
        score(mg, ma, ex, pa, wi, inv);
        m_exact = ex; m_partial = pa; m_win = wi; m_inv = inv; m_done = 1;
      end
      if (active && edge_n == acc_e + 11) begin
        active = 0;
      end else if (!active && bus.start) begin
        active = 1; acc_e = edge_n; mg = bus.guess; ma = bus.answer;
      end
      m_busy = active ? 1 : 0;
    end
  end

  always @(negedge Clk) begin
    check("busy",    8'(bus.busy),    8'(m_busy));
    check("done",    8'(bus.done),    8'(m_done));
    check("exact",   8'(bus.exact),   8'(m_exact));
    check("partial", 8'(bus.partial), 8'(m_partial));
    check("win",     8'(bus.win),     8'(m_win));
`ifdef GUESS_VALIDATE_EN
    check("invalid", 8'(bus.invalid), 8'(m_inv));
`endif
  end

  task automatic do_start(input logic [11:0] g, input logic [11:0] a);
    @(negedge Clk);
    bus.start  = 1'b1;
    bus.guess  = g;
    bus.answer = a;
    @(negedge Clk);
    bus.start  = 1'b0;
    bus.guess  = 12'($urandom);
    bus.answer = 12'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    if (!bus.done) check("done_timeout", 8'(bus.done), 8'd1);
  endtask

  function automatic logic [11:0] rand_word();
    logic [11:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      int r, s;
      r = int'($urandom_range(0, 15));
      s = (r == 13) ? 0 : (r == 14) ? 7 : (r % 6) + 1;
      w = w | (12'(s) << (3 * i));
    end
    return w;
  endfunction

  initial begin
    int lat, dones, ex, pa, wi, inv, sel;
    logic [11:0] g, a;
    Reset = 1'b1; bus.start = 1'b0; bus.guess = '0; bus.answer = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy",  8'(bus.busy),  8'd0);
    check("rst_exact", 8'(bus.exact), 8'd0);
    Reset = 1'b0;

    // Pin the model against hand-scored cases.
    score(pack(1, 1, 2, 2), pack(1, 2, 1, 3), ex, pa, wi, inv);
    check("model_dup_exact",   8'(ex), 8'd1);
    check("model_dup_partial", 8'(pa), 8'd2);

    do_start(pack(1, 1, 1, 1), pack(1, 1, 1, 1));
    wait_done(lat);
    check("lat_all1", 8'(lat), 8'd11);
    check("all1_exact", 8'(bus.exact), 8'd4);
    check("all1_partial", 8'(bus.partial), 8'd0);
    check("all1_win", 8'(bus.win), 8'd1);

    do_start(pack(1, 2, 3, 4), pack(4, 3, 2, 1));
    wait_done(lat);
    check("perm_exact", 8'(bus.exact), 8'd0);
    check("perm_partial", 8'(bus.partial), 8'd4);
    check("perm_win", 8'(bus.win), 8'd0);

    do_start(pack(1, 1, 2, 2), pack(1, 2, 1, 3));
    wait_done(lat);
    check("dup_exact", 8'(bus.exact), 8'd1);
    check("dup_partial", 8'(bus.partial), 8'd2);

    do_start(pack(0, 0, 0, 0), pack(1, 1, 1, 1));
    wait_done(lat);
    check("empty_exact", 8'(bus.exact), 8'd0);
    check("empty_partial", 8'(bus.partial), 8'd0);
`ifdef GUESS_VALIDATE_EN
    check("empty_invalid", 8'(bus.invalid), 8'd1);
`endif

    // Starts while busy and in the DONE cycle must be dropped.
    do_start(pack(1, 2, 3, 4), pack(1, 2, 4, 3));
    dones = 0;
    for (int n = 2; n <= 26; n++) begin
      @(negedge Clk);
      bus.start = (n == 3 || n == 11) ? 1'b1 : 1'b0;
      bus.guess = pack(2, 2, 2, 2); bus.answer = pack(2, 2, 2, 2);
      if (bus.done) begin
        dones++;
        check("ign_exact", 8'(bus.exact), 8'd2);
        check("ign_partial", 8'(bus.partial), 8'd2);
      end
    end
    bus.start = 1'b0;
    check("ign_done_count", 8'(dones), 8'd1);

    // Reset mid-operation.
    do_start(pack(3, 3, 3, 3), pack(3, 3, 3, 3));
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midrst_busy", 8'(bus.busy), 8'd0);
    check("midrst_exact", 8'(bus.exact), 8'd0);
    check("midrst_partial", 8'(bus.partial), 8'd0);
    dones = 0;
    repeat (15) begin
      @(negedge Clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", 8'(dones), 8'd0);
    do_start(pack(1, 2, 3, 4), pack(1, 2, 3, 5));
    wait_done(lat);
    check("post_rst_exact", 8'(bus.exact), 8'd3);
    check("post_rst_partial", 8'(bus.partial), 8'd0);

    // Randomized operations with stray start pulses.
    repeat (150) begin
      g = rand_word();
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? g : (sel == 1) ? 12'((g << 3) | (g >> 9)) : rand_word();
      do_start(g, a);
      lat = 1;
      while (!bus.done && lat < 20) begin
        @(negedge Clk);
        lat++;
        bus.start = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
        bus.guess = rand_word(); bus.answer = rand_word();
      end
      bus.start = 1'b0;
      if (!bus.done) check("rand_timeout", 8'(bus.done), 8'd1);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    repeat (15) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mastermind_scorer.md
Name: mastermind_scorer

Overview:
- Downstream of mastermind_core, on the same Clk.
- Takes a submitted 4-slot guess and the secret answer, and computes the classic Mastermind feedback over several cycles: exact count (right colour, right slot) and partial count (right colour, wrong slot).
- Results drive the feedback-peg area of mastermind_vga and the game-over decision: win when exact equals N_POS.
- Start is pulsed by the top when mastermind_core leaves its check state.

Parameters:
- N_POS, 4, slots per guess; slot i occupies bits [i*COLOR_W +: COLOR_W].
- COLOR_W, 3, bits per slot colour code.
- N_COLORS, 6, legal colours are 1..N_COLORS; 0 means empty; codes above N_COLORS are illegal.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- guess  in  N_POS*COLOR_W  guess word; latched on accepted start.
- answer  in  N_POS*COLOR_W  secret word; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- exact  out  3  exact-match count, 0..N_POS.
- partial  out  3  colour-only match count, 0..N_POS.
- win  out  1  exact == N_POS; updated with done.
- invalid  out  1  present only with GUESS_VALIDATE_EN.

Behaviour:
- Reset: state IDLE; busy=0, done=0, exact=0, partial=0, win=0, invalid=0; all internal accumulators cleared.
- All outputs are registered.
- FSM states: IDLE -> EXACT -> COUNT -> DONE -> IDLE.
- IDLE:
  - start=1 latches guess and answer into g_q and a_q, clears exact_acc and total_acc, sets pos=0, and goes to EXACT.
  - start=0 stays in IDLE.
- EXACT (N_POS cycles, pos 0..N_POS-1):
  - If g_q[pos]==a_q[pos] and the colour is in 1..N_COLORS, exact_acc increments.
  - After pos=N_POS-1, set c=1 and go to COUNT.
- COUNT (N_COLORS cycles, c 1..N_COLORS):
  - Combinationally count occurrences of c in g_q (ng) and in a_q (na).
  - Add min(ng,na) to total_acc.
  - After c=N_COLORS, go to DONE.
- DONE (1 cycle):
  - exact <= exact_acc; partial <= total_acc - exact_acc; win <= (exact_acc==N_POS); done=1.
  - Next cycle returns to IDLE.
- Latency: start sampled at edge k; done high in cycle k+1+N_POS+N_COLORS (cycle k+11 at defaults).
- Result hold: exact, partial and win hold their values until the next DONE. They are not cleared by a new start.
- Empty (0) and illegal (>N_COLORS) codes never contribute to exact or total.
- Width rule: total_acc is 4 bits, and total_acc >= exact_acc always holds, so the subtraction never underflows.
- start while busy is ignored, with no queuing. start coincident with DONE is also ignored.
- guess and answer may change freely after acceptance; only g_q and a_q are used.
- Reset mid-operation: returns to IDLE next edge, outputs go to reset values, and no done pulse is issued.

Optional Feature:
- Macro: GUESS_VALIDATE_EN.
- Defined:
  - invalid port exists.
  - During EXACT, any guess slot that is 0 or >N_COLORS sets a sticky flag.
  - On DONE the flag drives invalid=1 and forces exact=0, partial=0, win=0. Latency is unchanged.
  - invalid holds until the next DONE and is cleared by reset.
- Undefined:
  - No invalid port; empty and illegal slots are simply non-matching.

Decomposition:
- Package mastermind_pkg:
  - Constants N_POS, COLOR_W, N_COLORS, COLOR_EMPTY=0.
  - Scorer state encoding (IDLE, EXACT, COUNT, DONE).
  - Slot-extract helper function.
- One sub-module, mastermind_color_count: combinational. Inputs are a word and colour c; output is the occurrence count. Instantiated twice (guess and answer).

Test Plan:
- guess=answer={1,1,1,1} (12'b001_001_001_001), start at k -> done at k+11; exact=4, partial=0, win=1.
- guess slots {1,2,3,4}, answer slots {4,3,2,1} -> exact=0, partial=4, win=0.
- Duplicates: guess slots[0..3]={1,1,2,2}, answer={1,2,1,3} -> exact=1, partial=2.
- guess all 0, answer {1,1,1,1} -> exact=0, partial=0; with GUESS_VALIDATE_EN, invalid=1.
- Second start pulsed at k+3 and at the DONE cycle -> ignored: exactly one done, results from the first operands.
- Reset asserted at k+6 -> next cycle busy=0, exact=partial=win=0, and no done pulse; a new start then scores normally.
